iir_chan_sched: RTL and testbench
=================================

# iir_chan_sched

Time-multiplexed scheduler for the 2nd-order bandpass IIR section (transposed direct-form II, 14–32 Hz beta coefficients, Q27 scaling), serving NCH independent EEG channels with one shared 32×32 multiplier. Owns per-channel 64-bit history state in an internal register file and accepts one sample at a time with a valid/ready handshake. It returns the filtered sample tagged with its channel. It sits between the per-channel sample mux and the band-power stage.

## Interface
- NCH, 4, number of channels; power of two, ≥2; CW = clog2(NCH)
- SHIFT, 27, output arithmetic right-shift
- B1, 25109419; B2, 0; B3, -25109419; A2, -187539761; A3, 83998890 — signed 32-bit coefficients
- clk  in  1  clock; all state updates on the negative edge (negedge clk), matching the filter datapath
- reset  in  1  asynchronous, active-high
- in_valid  in  1  sample offered
- in_ready  out  1  high only in IDLE
- in_x  in  32  signed sample
- in_ch  in  CW  channel of in_x
- out_valid  out  1  result held until accepted
- out_ready  in  1  downstream accepts
- out_y  out  32  signed filtered sample
- out_ch  out  CW  channel of out_y
- clr_valid, clr_ch  in  1, CW  present only with IIR_SCHED_CLR_EN

## Operation
- Per channel c: s1[c], s2[c], signed 64-bit, reset to 0.
- Per sample (x, c): acc = s1 + B1·x; y = acc >>> SHIFT, truncated to the low 32 bits (wraps, no saturation); s1' = B2·x + s2 − A2·y; s2' = B3·x − A3·y. y is sign-extended to 64 bits for the feedback products. Products are 64-bit signed. Sums wrap modulo 2^64.
- One multiplier; one product per cycle. Operands: coefficient × x or coefficient × y.
- FSM states: IDLE, MB1, MB2, MA2, MB3, MA3, OUT.
- IDLE: in_ready=1. If in_valid, latch x and c, then go to MB1.
- MB1: compute acc and y; latch y.
- MB2: t1 = B2·x + s2[c].
- MA2: s1n = t1 − A2·y.
- MB3: t2 = B3·x.
- MA3: s2n = t2 − A3·y. Write s1n and s2n to channel c. Drive out_y=y, out_ch=c, out_valid=1. Go to OUT.
- OUT: hold out_valid, out_y and out_ch stable. On out_ready, clear out_valid and go to IDLE.
- Other channels' state is never modified by a sample.
- Reset (async, any state): all s1/s2 = 0, FSM = IDLE, out_valid=0, out_y=0, out_ch=0. Any in-flight sample is discarded with no writeback.

## Timing
- Reset values: in_ready=1, out_valid=0, out_y=0, out_ch=0.
- Input handshake at active edge k: in_valid & in_ready sampled high.
- out_valid rises after edge k+5. Latency is 5 cycles to first out_valid.
- Back-to-back throughput: one sample per 7 cycles (handshake, 5 compute, OUT with out_ready=1). in_ready stays low from edge k through the edge that retires OUT.
- Writeback occurs at edge k+5. A sample on the same channel accepted next therefore sees the updated state.
- in_x and in_ch may change after the handshake edge; they are latched at that edge.

## Configuration
- IIR_SCHED_CLR_EN defined: adds clr_valid and clr_ch.
  - Clear is honoured only in IDLE and takes priority over in_valid in the same cycle.
  - The clear zeroes s1[clr_ch] and s2[clr_ch] in one edge. in_ready stays high that cycle but no sample is accepted.
  - After the clear, the FSM stays in IDLE. Clear requests outside IDLE are ignored.
- Undefined: the ports are absent. State is zeroed only by reset.

## Test plan
- Impulse: reset, then ch0 x=1048576 -> out_y=196167, out_ch=0, out_valid after 5 cycles. Next, ch0 x=0 -> out_y equals the bit-accurate golden model (≈274100).
- Channel isolation: the impulse above on ch0, then ch1 x=0 -> out_y=0, out_ch=1. Afterwards ch0 x=0 still matches the golden model continuation.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid, out_y and out_ch stay constant and in_ready=0 throughout. Raise out_ready -> in_ready=1 on the next cycle.
- Reset mid-operation: assert reset in MA2 of a ch2 sample -> out_valid=0 and in_ready=1 immediately. Then ch2 x=0 -> out_y=0.
- Long run: 4 channels interleaved, 1000 random samples each -> every out_y matches the golden model and throughput is 7 cycles per sample.
- IIR_SCHED_CLR_EN: impulse on ch3, then clr_valid with clr_ch=3 and in_valid together in IDLE -> no sample is accepted. Then ch3 x=0 -> out_y=0.

Source files
------------

// File: rtl/iir_chan_sched.sv
// -----------------------------------------------------------------------------
// iir_chan_sched
//
// Time-multiplexed scheduler for a 2nd-order bandpass IIR section
// (transposed direct-form II, Q27 coefficients). It serves NCH independent
// channels and uses one shared 32x32 signed multiplier, which produces one
// product per cycle. Each channel keeps its own 64-bit s1/s2 history in an
// internal register file.
//
// All state updates happen on the falling edge of clk_i, to match the
// filter datapath.
//
// Optional feature macro: IIR_SCHED_CLR_EN
//   When it is defined, clr_valid_i and clr_ch_i are added. They zero the
//   history of one channel while the scheduler is idle.
//
// Ports
//   clk_i        clock (state updates on negedge)
//   reset_i      asynchronous, active-high reset
//   clr_valid_i  clear request (only with IIR_SCHED_CLR_EN)
//   clr_ch_i     channel to clear (only with IIR_SCHED_CLR_EN)
//   in_valid_i   sample offered
//   in_ready_o   high only while IDLE
//   in_x_i       signed 32-bit input sample
//   in_ch_i      channel of in_x_i
//   out_valid_o  result valid, held until accepted
//   out_ready_i  downstream accepts the result
//   out_y_o      signed 32-bit filtered sample
//   out_ch_o     channel of out_y_o
// -----------------------------------------------------------------------------
module iir_chan_sched #(
    parameter int                 NCH   = 4,
    parameter int                 SHIFT = 27,
    parameter logic signed [31:0] B1    = 32'sd25109419,
    parameter logic signed [31:0] B2    = 32'sd0,
    parameter logic signed [31:0] B3    = -32'sd25109419,
    parameter logic signed [31:0] A2    = -32'sd187539761,
    parameter logic signed [31:0] A3    = 32'sd83998890,
    localparam int                CW    = $clog2(NCH)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
`ifdef IIR_SCHED_CLR_EN
    input  logic                 clr_valid_i,
    input  logic [CW-1:0]        clr_ch_i,
`endif
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic signed [31:0]   in_x_i,
    input  logic [CW-1:0]        in_ch_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic signed [31:0]   out_y_o,
    output logic [CW-1:0]        out_ch_o
);

    // One multiplier pass per state. Writeback happens on the MA3 -> OUT edge.
    typedef enum logic [2:0] {
        IDLE,
        MB1,
        MB2,
        MA2,
        MB3,
        MA3,
        OUT
    } state_e;

    state_e state_q, state_d;

    // Per-channel filter history
    logic signed [63:0] s1_q [NCH];
    logic signed [63:0] s2_q [NCH];

    // Latched sample and intermediate results
    logic signed [31:0] x_q, x_d;
    logic [CW-1:0]      ch_q, ch_d;
    logic signed [31:0] y_q, y_d;
    logic signed [63:0] t_q, t_d;       // partial sum shared by MB2/MA2 and MB3/MA3
    logic signed [63:0] s1n_q, s1n_d;   // new s1, held until the MA3 writeback
    logic signed [63:0] s2n;

    logic               out_valid_q, out_valid_d;
    logic signed [31:0] out_y_q, out_y_d;
    logic [CW-1:0]      out_ch_q, out_ch_d;

    logic               wr_en;
    logic               clr_en;
    logic               clr_req;
    logic [CW-1:0]      clr_ch;

`ifdef IIR_SCHED_CLR_EN
    assign clr_req = clr_valid_i;
    assign clr_ch  = clr_ch_i;
`else
    assign clr_req = 1'b0;
    assign clr_ch  = '0;
`endif

    // ---------------- shared multiplier ----------------
    logic signed [31:0] mul_coef;
    logic signed [31:0] mul_opnd;
    logic signed [63:0] prod;

    // NOTE: every signal driven in an always_comb gets a default before the
    // case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        mul_coef = B1;
        mul_opnd = x_q;
        unique case (state_q)
            MB2:     mul_coef = B2;
            MA2: begin
                mul_coef = A2;
                mul_opnd = y_q;
            end
            MB3:     mul_coef = B3;
            MA3: begin
                mul_coef = A3;
                mul_opnd = y_q;
            end
            default: ;
        endcase
    end

    // Operands are sign-extended to 64 bits, so the product is exact.
    assign prod = 64'(mul_coef) * 64'(mul_opnd);
    assign s2n  = t_q - prod;

    // ---------------- next-state / datapath ----------------
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        ch_d        = ch_q;
        y_d         = y_q;
        t_d         = t_q;
        s1n_d       = s1n_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_ch_d    = out_ch_q;
        wr_en       = 1'b0;
        clr_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A clear wins over a sample offered in the same cycle.
                if (clr_req) begin
                    clr_en = 1'b1;
                end else if (in_valid_i) begin
                    x_d     = in_x_i;
                    ch_d    = in_ch_i;
                    state_d = MB1;
                end
            end
            MB1: begin
                // y wraps to 32 bits. No saturation is applied.
                y_d     = 32'((s1_q[ch_q] + prod) >>> SHIFT);
                state_d = MB2;
            end
            MB2: begin
                t_d     = prod + s2_q[ch_q];
                state_d = MA2;
            end
            MA2: begin
                s1n_d   = t_q - prod;
                state_d = MB3;
            end
            MB3: begin
                t_d     = prod;
                state_d = MA3;
            end
            MA3: begin
                wr_en       = 1'b1;
                out_valid_d = 1'b1;
                out_y_d     = y_q;
                out_ch_d    = ch_q;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- registers ----------------
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then updates from the values that were present before the edge.
    always_ff @(negedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            x_q         <= '0;
            ch_q        <= '0;
            y_q         <= '0;
            t_q         <= '0;
            s1n_q       <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            ch_q        <= ch_d;
            y_q         <= y_d;
            t_q         <= t_d;
            s1n_q       <= s1n_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_ch_q    <= out_ch_d;
        end
    end

    // NOTE: this history file is small flop storage, not a RAM macro. It is
    // reset on purpose, because every channel's filter must restart from zero
    // state. A reset in mid-sample discards that sample, since wr_en is never
    // raised for it.
    always_ff @(negedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NCH; i++) begin
                s1_q[i] <= '0;
                s2_q[i] <= '0;
            end
        end else if (clr_en) begin
            s1_q[clr_ch] <= '0;
            s2_q[clr_ch] <= '0;
        end else if (wr_en) begin
            s1_q[ch_q] <= s1n_q;
            s2_q[ch_q] <= s2n;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = out_valid_q;
    assign out_y_o     = out_y_q;
    assign out_ch_o    = out_ch_q;

endmodule

// File: tb/tb_iir_chan_sched.sv
// -----------------------------------------------------------------------------
// tb_iir_chan_sched
//
// Scoreboard bench for iir_chan_sched. The driver pushes the expected
// {y, ch, handshake cycle} entry when a sample is accepted. A monitor pops
// and compares whenever out_valid and out_ready are both high. Expected y
// comes from a plain-arithmetic model of the filter equations.
//
// Inputs are driven just after the falling (active) edge. Outputs are
// sampled on the rising edge.
// -----------------------------------------------------------------------------
module tb_iir_chan_sched;

    localparam int NCH = 4;
    localparam int CW  = 2;

    localparam longint B1 = 25109419;
    localparam longint B2 = 0;
    localparam longint B3 = -25109419;
    localparam longint A2 = -187539761;
    localparam longint A3 = 83998890;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic signed [31:0]  in_x;
    logic [CW-1:0]       in_ch;
    logic                out_valid;
    logic                out_ready;
    logic signed [31:0]  out_y;
    logic [CW-1:0]       out_ch;
`ifdef IIR_SCHED_CLR_EN
    logic                clr_valid;
    logic [CW-1:0]       clr_ch;
`endif

    iir_chan_sched #(.NCH(NCH)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
`ifdef IIR_SCHED_CLR_EN
        .clr_valid_i (clr_valid),
        .clr_ch_i    (clr_ch),
`endif
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_x_i      (in_x),
        .in_ch_i     (in_ch),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_y_o     (out_y),
        .out_ch_o    (out_ch)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;  // count of active (falling) edges

    always @(negedge clk) cyc++;

    typedef struct {
        int y;
        int ch;
        int hs;
    } exp_t;

    exp_t   sbq[$];
    longint s1m[NCH];
    longint s2m[NCH];
    int     last_y  = -1;
    int     last_ch = -1;
    int     last_hs = -1;
    bit     chk_tput = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_msg(input string name);
        total++;
        bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference filter: the direct section equations on 64-bit wrapping ints.
    function automatic int model_step(input int x, input int ch);
        longint acc;
        longint xl;
        longint yl;
        int     y;
        xl  = longint'(x);
        acc = s1m[ch] + B1 * xl;
        y   = int'(acc >>> 27);
        yl  = longint'(y);
        s1m[ch] = B2 * xl + s2m[ch] - A2 * yl;
        s2m[ch] = B3 * xl - A3 * yl;
        return y;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            s1m[i] = 0;
            s2m[i] = 0;
        end
    endfunction

    // Offer one sample and hold it until it is accepted. Call this just after
    // a falling edge.
    task automatic send(input int x, input int ch);
        bit   took;
        int   budget;
        exp_t e;
        budget   = 0;
        took     = 1'b0;
        in_valid = 1'b1;
        in_x     = x;
        in_ch    = CW'(ch);
        while (!took && budget < 200) begin
            took = in_ready;
            @(negedge clk);
            #1;
            budget++;
        end
        in_valid = 1'b0;
        in_x     = $urandom;  // inputs are free to change after the handshake
        in_ch    = CW'($urandom);
        if (!took) begin
            fail_msg("send_timeout");
            return;
        end
        if (chk_tput && last_hs >= 0) check("throughput", cyc - last_hs, 7);
        last_hs = cyc;
        e.y  = model_step(x, ch);
        e.ch = ch;
        e.hs = cyc;
        sbq.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || !in_ready) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) fail_msg("drain_timeout");
    endtask

    // Monitor: checks latency on each rising out_valid, and pops/compares on
    // every accepted output.
    bit prev_v = 1'b0;
    always @(posedge clk) begin
        exp_t e;
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v && sbq.size() > 0)
                check("latency", cyc - sbq[0].hs, 5);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    fail_msg("unexpected_output");
                end else begin
                    e = sbq.pop_front();
                    check("out_y", out_y, e.y);
                    check("out_ch", out_ch, e.ch);
                    last_y  = out_y;
                    last_ch = out_ch;
                end
            end
            prev_v = out_valid;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_ch     = '0;
        out_ready = 1'b1;
`ifdef IIR_SCHED_CLR_EN
        clr_valid = 1'b0;
        clr_ch    = '0;
`endif
        model_reset();
        #23;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_y", out_y, 0);
        check("rst_out_ch", out_ch, 0);
        reset = 1'b0;
        @(negedge clk);
        #1;

        // Impulse on ch0, then a zero on ch1 (isolation), then the ch0 continuation
        send(1048576, 0);
        drain();
        check("impulse_y", last_y, 196167);
        check("impulse_ch", last_ch, 0);
        send(0, 1);
        drain();
        check("iso_ch1_y", last_y, 0);
        check("iso_ch1_ch", last_ch, 1);
        send(0, 0);
        drain();

        // Backpressure: the result must hold steady while out_ready is low
        out_ready = 1'b0;
        send(12345678, 2);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!out_valid) fail_msg("bp_wait_valid");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            if (sbq.size() > 0) begin
                check("bp_out_y", out_y, sbq[0].y);
                check("bp_out_ch", out_ch, sbq[0].ch);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_release_in_ready", in_ready, 1);
        drain();

        // Reset while a ch2 sample is in MA2
        send(500000, 2);
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        reset = 1'b1;
        sbq.delete();
        model_reset();
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        #2;
        reset = 1'b0;
        @(negedge clk);
        #1;
        send(0, 2);
        drain();
        check("midrst_ch2_y", last_y, 0);

        // Long run: 4 channels interleaved, random samples, back-to-back
        last_hs  = -1;
        chk_tput = 1'b1;
        for (int i = 0; i < 4 * 1000; i++) send(int'($urandom), i % NCH);
        chk_tput = 1'b0;
        drain();

`ifdef IIR_SCHED_CLR_EN
        // A clear together with in_valid: the clear wins and no sample is accepted
        send(1048576, 3);
        drain();
        clr_valid = 1'b1;
        clr_ch    = 2'd3;
        in_valid  = 1'b1;
        in_x      = 777;
        in_ch     = 2'd3;
        @(negedge clk);
        #1;
        check("clr_in_ready", in_ready, 1);
        clr_valid = 1'b0;
        in_valid  = 1'b0;
        s1m[3] = 0;
        s2m[3] = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            check("clr_no_output", out_valid, 0);
        end
        send(0, 3);
        drain();
        check("clr_ch3_y", last_y, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
